// File: rtl/coef_pack64_pkg.sv
// Shared constants and state encoding for the 64-bit coefficient packer.
package coef_pack64_pkg;

  localparam int LANE_W     = 16;
  localparam int LANES      = 4;
  localparam int BUS_W      = 64;
  localparam int ACC_W      = LANE_W * (LANES - 1);
  localparam int LANE_IDX_W = 2;

  localparam logic [LANE_IDX_W-1:0] LAST_LANE = 2'd3;

  typedef enum logic {
    FILL  = 1'b0,
    FLUSH = 1'b1
  } st_t;

endpackage

// File: rtl/pack64_outreg.sv
// One-entry valid/data output register with a ready/valid handshake on each side.
module pack64_outreg
  import coef_pack64_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld,
  input  logic [BUS_W-1:0] push_word,
  input  logic             push_last,
  output logic             push_rdy,
  output logic             pop_vld,
  output logic [BUS_W-1:0] pop_word,
  output logic             pop_last,
  input  logic             pop_rdy
);

  logic             vld_p1;
  logic [BUS_W-1:0] word_p1;
  logic             last_p1;

  // Accept when empty or when the held word drains in this same cycle.
  assign push_rdy = ~vld_p1 | pop_rdy;

  // ---- stage p1: registered output word ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      word_p1 <= '0;
      last_p1 <= 1'b0;
    end else if (push_vld && push_rdy) begin
      vld_p1  <= 1'b1;
      word_p1 <= push_word;
      last_p1 <= push_last;
    end else if (pop_rdy) begin
      vld_p1  <= 1'b0;
    end
  end

  assign pop_vld  = vld_p1 & pop_rdy;
  assign pop_word = word_p1;
  assign pop_last = last_p1;

endmodule

// File: rtl/coef_pack64.sv
// Packs masked 16-bit coefficients four per 64-bit word; short final groups are zero-padded.
// Optional PACK64_OUTREG_EN inserts a one-entry output register (one extra cycle of latency).
module coef_pack64
  import coef_pack64_pkg::*;
#(
  parameter int LOGQ = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LANE_W-1:0] in_coef,
  input  logic              in_isReady,
  output logic              in_canReceive,
  input  logic              in_isLast,
  output logic [BUS_W-1:0]  out_word,
  output logic              out_isReady,
  input  logic              out_canReceive,
  output logic              out_isLast
);

  function automatic logic [LANE_W-1:0] mask_coef(input logic [LANE_W-1:0] c);
    logic [LANE_W:0] mk;
    // Built one bit wider so LOGQ=16 still yields an all-ones mask.
    mk = ({{LANE_W{1'b0}}, 1'b1} << LOGQ) - {{LANE_W{1'b0}}, 1'b1};
    return c & mk[LANE_W-1:0];
  endfunction

  st_t                   st, st_nxt;
  logic [LANE_IDX_W-1:0] lane, lane_nxt;
  logic [ACC_W-1:0]      acc, acc_nxt, acc_ins;
  logic [LANE_W-1:0]     m;
  logic                  accept;
  logic                  sink_rdy;
  logic                  word_vld;
  logic [BUS_W-1:0]      word_data;
  logic                  word_last;

  assign m = mask_coef(in_coef);

  // A lane-3 accept is only offered when the word can leave in the same cycle.
  assign in_canReceive = (st == FILL) && ((lane != LAST_LANE) || sink_rdy);
  assign accept        = in_isReady & in_canReceive;

  for (genvar k = 0; k < LANES - 1; k++) begin : g_lane
    assign acc_ins[k*LANE_W +: LANE_W] =
      (lane == LANE_IDX_W'(k)) ? m : acc[k*LANE_W +: LANE_W];
  end

  // ---- stage p0: lane accumulator and fill/flush state ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st   <= FILL;
      lane <= '0;
      acc  <= '0;
    end else begin
      st   <= st_nxt;
      lane <= lane_nxt;
      acc  <= acc_nxt;
    end
  end

  always_comb begin
    st_nxt   = st;
    lane_nxt = lane;
    acc_nxt  = acc;
    if (st == FLUSH) begin
      if (sink_rdy) begin
        st_nxt   = FILL;
        lane_nxt = '0;
        acc_nxt  = '0;
      end
    end else if (accept) begin
      if (lane == LAST_LANE) begin
        lane_nxt = '0;
        acc_nxt  = '0;
      end else begin
        acc_nxt = acc_ins;
        if (in_isLast) begin
          st_nxt = FLUSH;
        end else begin
          lane_nxt = lane + 2'd1;
        end
      end
    end
  end

  always_comb begin
    word_vld  = 1'b0;
    word_data = '0;
    word_last = 1'b0;
    if (st == FLUSH) begin
      word_vld  = sink_rdy;
      word_data = {{LANE_W{1'b0}}, acc};
      word_last = 1'b1;
    end else if (accept && (lane == LAST_LANE)) begin
      word_vld  = 1'b1;
      word_data = {m, acc};
      word_last = in_isLast;
    end
  end

`ifdef PACK64_OUTREG_EN
  logic push_rdy;

  pack64_outreg u_outreg (
    .clk       (clk),
    .rst       (rst),
    .push_vld  (word_vld),
    .push_word (word_data),
    .push_last (word_last),
    .push_rdy  (push_rdy),
    .pop_vld   (out_isReady),
    .pop_word  (out_word),
    .pop_last  (out_isLast),
    .pop_rdy   (out_canReceive)
  );

  assign sink_rdy = push_rdy;
`else
  assign sink_rdy    = out_canReceive;
  assign out_isReady = word_vld;
  assign out_word    = word_data;
  assign out_isLast  = word_last;
`endif

endmodule
